// File: rtl/gpr_scan_reader.sv
// gpr_scan_reader: streams all 32 GPRs, two per read cycle, over a valid/ready port.
module gpr_scan_reader (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic [4:0]  Rs,
  output logic [4:0]  Rt,
  input  logic [31:0] busA,
  input  logic [31:0] busB,
  output logic [31:0] data_out,
  output logic [4:0]  data_idx,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, READ, OUT_A, OUT_B, DONE} state_t;
  state_t      state_q, state_d;
  logic [3:0]  p_q, p_d;
  logic [4:0]  rs_q, rs_d, rt_q, rt_d, idx_q, idx_d;
  logic [31:0] buf_a_q, buf_a_d, buf_b_q, buf_b_d, out_q, out_d;
  logic        valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    if (abort && state_q != IDLE) state_d = IDLE;
    else
      case (state_q)
        IDLE: if (start) begin
          state_d = READ;
          p_d     = 4'd0;
          rs_d    = 5'd0;
          rt_d    = 5'd1;
        end
        READ:  state_d = OUT_A;
        OUT_A: if (data_ready) state_d = OUT_B;
        OUT_B: if (data_ready) begin
          if (p_q == 4'd15) state_d = DONE;
          else begin
            state_d = READ;
            p_d     = p_q + 4'd1;
            rs_d    = {p_d, 1'b0};
            rt_d    = {p_d, 1'b1};
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    buf_a_d = state_q == READ ? busA : buf_a_q;
    buf_b_d = state_q == READ ? busB : buf_b_q;
    // Outputs are precomputed from the next state so every port comes straight from a flop.
    out_d   = state_d == OUT_A ? buf_a_d : state_d == OUT_B ? buf_b_q : out_q;
    idx_d   = state_d == OUT_A ? {p_d, 1'b0} : state_d == OUT_B ? {p_d, 1'b1} : idx_q;
    valid_d = state_d == OUT_A || state_d == OUT_B;
    busy_d  = state_d != IDLE;
    done_d  = state_d == DONE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      p_q     <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      idx_q   <= '0;
      buf_a_q <= '0;
      buf_b_q <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      idx_q   <= idx_d;
      buf_a_q <= buf_a_d;
      buf_b_q <= buf_b_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  assign Rs         = rs_q;
  assign Rt         = rt_q;
  assign data_out   = out_q;
  assign data_idx   = idx_q;
  assign data_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
endmodule

// File: tb/tb_gpr_scan_reader.sv
// tb_gpr_scan_reader: random-ready dumps checked against an in-order word list built from the register file.
module tb_gpr_scan_reader;
  logic        clk = 0, reset = 1, start = 0, abort = 0, data_ready = 0;
  logic [4:0]  Rs, Rt, data_idx;
  logic [31:0] busA, busB, data_out;
  logic        data_valid, busy, done;
  logic [31:0] regs [32];
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  assign busA = regs[Rs];
  assign busB = regs[Rt];
  gpr_scan_reader dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .Rs(Rs), .Rt(Rt),
    .busA(busA), .busB(busB), .data_out(data_out), .data_idx(data_idx),
    .data_valid(data_valid), .data_ready(data_ready), .busy(busy), .done(done)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_valid"}, 32'(data_valid), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask
  // mode: 0 ready always, 1 ready pattern 1,0,0,1, 2 random ready
  task automatic dump(input int mode, input bit spam, input int abort_idx, input int reset_n);
    int exp_idx = 0, n = 1, rc = 0;
    bit pv = 0, pr = 0, fin = 0, ready;
    logic [31:0] pd = 0;
    logic [4:0] pi = 0;
    start = 1;
    tick();
    start = spam;
    while (!fin && n < 400) begin
      ready = mode == 0 ? 1'b1 : mode == 1 ? (rc % 4 == 0 || rc % 4 == 3) : 1'($urandom % 2);
      rc++;
      if (n == reset_n) begin
        reset = 1;
        #1;
        check("rst_rs", 32'(Rs), 32'd0);
        check("rst_rt", 32'(Rt), 32'd0);
        check("rst_data", data_out, 32'd0);
        check("rst_idx", 32'(data_idx), 32'd0);
        check_idle("rst");
        tick();
        tick();
        reset = 0;
        repeat (4) begin
          tick();
          check_idle("post_rst");
        end
        return;
      end
      if (pv && !pr) begin
        check("hold_valid", 32'(data_valid), 32'd1);
        check("hold_data", data_out, pd);
        check("hold_idx", 32'(data_idx), 32'(pi));
      end
      check("busy", 32'(busy), 32'd1);
      if (mode == 0 && n % 3 == 1 && n < 49) begin
        check("read_rs", 32'(Rs), 32'(2 * (n / 3)));
        check("read_rt", 32'(Rt), 32'(2 * (n / 3) + 1));
        check("read_valid", 32'(data_valid), 32'd0);
      end
      if (abort_idx >= 0 && data_valid && data_idx == 5'(abort_idx)) begin
        abort = 1;
        data_ready = 1;
        tick();
        abort = 0;
        check_idle("abort");
        repeat (5) begin
          tick();
          check_idle("post_abort");
        end
        return;
      end
      if (data_valid && ready) begin
        check("idx", 32'(data_idx), 32'(exp_idx));
        check("data", data_out, regs[exp_idx % 32]);
        exp_idx++;
      end
      if (done) begin
        check("done_count", 32'(exp_idx), 32'd32);
        if (mode == 0) check("done_cycle", 32'(n), 32'd49);
        fin = 1;
      end
      data_ready = ready;
      pv = data_valid;
      pr = ready;
      pd = data_out;
      pi = data_idx;
      if (!fin) begin
        tick();
        n++;
      end
    end
    if (!fin) check("timeout", 32'd0, 32'd1);
    tick();
    start = 0;
    data_ready = 0;
    check_idle("after_done");
    repeat (3) begin
      tick();
      check_idle("stay_idle");
    end
  endtask
  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'(100 + i);
    tick();
    tick();
    check("reset_rs", 32'(Rs), 32'd0);
    check("reset_rt", 32'(Rt), 32'd0);
    check("reset_data", data_out, 32'd0);
    check("reset_idx", 32'(data_idx), 32'd0);
    check_idle("reset");
    reset = 0;
    tick();
    check_idle("idle_no_start");
    dump(0, 0, -1, 0);
    dump(1, 0, -1, 0);
    dump(2, 0, 15, 0);
    dump(0, 0, -1, 0);
    dump(0, 0, -1, 10);
    dump(0, 1, -1, 0);
    regs[4] = 32'd80;
    dump(0, 0, -1, 0);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      dump(2, 0, -1, 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
